// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 -- eight-way round-robin arbiter with a bounded hold time.
//
// A requester keeps the grant for as long as it keeps requesting. Once it
// has held the grant for MAX_HOLD consecutive cycles and someone else is
// waiting, it is forced to hand over. A new owner is granted at the same
// edge the old one releases, so there is no idle cycle between owners.
// All outputs are registered.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req[7:0]   request vector, bit i = requester i
//   gnt[7:0]   one-hot grant (all zero when no owner)
//   gnt_idx    binary index of the current owner
//   gnt_valid  high while a grant is held
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic [7:0] gnt_q, gnt_d;

  logic [7:0] others;
  logic       own_req;
  logic [2:0] win_idle;
  logic [2:0] win_next;

  // First set bit of r, scanning base, base+1, ... modulo 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
    logic [2:0] pick;
    logic [2:0] cand;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = base + 3'(i);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    own_req  = req[idx_q];
    others   = req & ~(8'b1 << idx_q);
    win_idle = rr_pick(req, ptr_q);
    // Handover search starts just past the current owner; only the other
    // requesters are candidates, so the owner never re-wins a forced handover.
    win_next = rr_pick(others, idx_q + 3'd1);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    idx_d      = idx_q;
    valid_d    = valid_q;

    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d    = GRANT;
          idx_d      = win_idle;
          valid_d    = 1'b1;
          hold_cnt_d = 8'd1;
          ptr_d      = win_idle + 3'd1;
        end
      end
      GRANT: begin
        if (own_req && (hold_cnt_q < MaxHold || others == '0)) begin
          if (hold_cnt_q < MaxHold) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end else if (others != '0) begin
          idx_d      = win_next;
          hold_cnt_d = 8'd1;
          ptr_d      = win_next + 3'd1;
        end else begin
          state_d    = IDLE;
          valid_d    = 1'b0;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    gnt_d = valid_d ? (8'b1 << idx_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      gnt_q      <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed testbench for rr_arbiter_8 with MAX_HOLD = 4.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int unsigned n_checks;
  int unsigned n_pass;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
  endtask

  task automatic expect_owner(input string tag, input logic [2:0] idx);
    check({tag, ".valid"}, 32'(gnt_valid), 32'd1);
    check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    check({tag, ".gnt"}, 32'(gnt), 32'(8'b1 << idx));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".valid"}, 32'(gnt_valid), 32'd0);
    check({tag, ".gnt"}, 32'(gnt), 32'd0);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse that spans one clock edge, released mid-cycle.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    expect_idle("rst_async");
    check("rst_idx", 32'(gnt_idx), 32'd0);
    tick();
    expect_idle("rst_held");
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    req      = '0;
    #2;
    expect_idle("por");
    check("por_idx", 32'(gnt_idx), 32'd0);
    tick();
    rst = 1'b0;

    // No requests: nothing is ever granted.
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_idle($sformatf("noreq%0d", i));
    end

    // Basic grant, release to another requester, release to idle.
    req = 8'b0000_0101;
    tick();
    expect_owner("basic0", 3'd0);
    req = 8'b0000_0100;
    tick();
    expect_owner("basic2", 3'd2);
    req = 8'h00;
    tick();
    expect_idle("basic_idle");

    // All requesting: each owner held exactly 4 cycles, 0..7 then back to 0.
    pulse_reset();
    req = 8'hFF;
    for (int o = 0; o < 9; o++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        expect_owner($sformatf("rot_o%0d_c%0d", o, c), 3'(o % 8));
      end
    end

    // Owner 0 releases to 7, then 7 releases to 0 (wrap), leaving ptr = 1.
    req = 8'h80;
    tick();
    expect_owner("to7", 3'd7);
    req = 8'h01;
    tick();
    expect_owner("wrap0", 3'd0);
    req = 8'h00;
    tick();
    expect_idle("wrap_idle");
    // With ptr = 1 the scan reaches 7 before wrapping to 0.
    req = 8'h81;
    tick();
    expect_owner("ptr1", 3'd7);
    req = 8'h00;
    tick();
    expect_idle("ptr_idle");

    // Lone requester keeps the grant indefinitely.
    req = 8'h08;
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_owner($sformatf("lone%0d", i), 3'd3);
    end
    // Hold count saturated at 4: a new requester forces handover at once.
    // Scan starts at 4 and wraps around to 2.
    req = 8'h0C;
    tick();
    expect_owner("sat_handover", 3'd2);
    // New owner has only held once, so it keeps the grant.
    tick();
    expect_owner("keep_below_max", 3'd2);
    req = 8'h00;
    tick();
    expect_idle("sat_idle");

    // Asynchronous reset while granted to 5 drops gnt before the next edge.
    req = 8'h20;
    tick();
    expect_owner("pre_rst5", 3'd5);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_valid", 32'(gnt_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    expect_owner("post_rst5", 3'd5);
    // ptr after that grant is 6: scan 6,7 then wraps to 0.
    req = 8'h00;
    tick();
    expect_idle("post_idle");
    req = 8'h11;
    tick();
    expect_owner("post_ptr", 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
